mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl.sv | 143 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Pipeline-facing bus of the multiply/divide unit: E-stage request, D-stage
// stall query and HI/LO read-back. The pipeline is the master, the MDU the slave.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, d_is_md, mf_sel,
        input  mf_data, busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b, d_is_md, mf_sel,
        output mf_data, busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and D-stage stall.
// Optional MADD accumulate (op 6) is built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);
    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      aLat;
    logic [31:0]      bLat;
    logic [2:0]       opLat;
    logic [31:0]      hiReg;
    logic [31:0]      loReg;
    logic             busyReg;

    logic [63:0]      prodS;
    logic [63:0]      prodU;
    logic [31:0]      quotS;
    logic [31:0]      remS;
    logic [31:0]      quotU;
    logic [31:0]      remU;
    logic             divZero;
    logic             isMulti;

    always_comb begin
        prodS   = 64'($signed(aLat)) * 64'($signed(bLat));
        prodU   = {32'd0, aLat} * {32'd0, bLat};
        divZero = (bLat == '0);
        quotS   = '0;
        remS    = '0;
        quotU   = '0;
        remU    = '0;
        if (!divZero) begin
            // Dividing by -1 is a plain negation; this also pins down the
            // 0x80000000 / -1 overflow case without relying on signed division.
            if (bLat == '1) begin
                quotS = 32'd0 - aLat;
                remS  = '0;
            end else begin
                quotS = $unsigned($signed(aLat) / $signed(bLat));
                remS  = $unsigned($signed(aLat) % $signed(bLat));
            end
            quotU = aLat / bLat;
            remU  = aLat % bLat;
        end
    end

`ifdef MDU_MADD_EN
    assign isMulti = (mdu.op <= 3'd3) || (mdu.op == 3'd6);
`else
    assign isMulti = (mdu.op <= 3'd3);
`endif

    assign mdu.stall_req = mdu.d_is_md & (busyReg | (mdu.start & isMulti));
    assign mdu.mf_data   = mdu.mf_sel ? loReg : hiReg;
    assign mdu.busy      = busyReg;
    assign mdu.hi        = hiReg;
    assign mdu.lo        = loReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            aLat    <= '0;
            bLat    <= '0;
            opLat   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            busyReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu.start) begin
                        case (mdu.op)
                            3'd0, 3'd1: begin
                                aLat    <= mdu.a;
                                bLat    <= mdu.b;
                                opLat   <= mdu.op;
                                counter <= CNT_W'(MUL_CYCLES);
                                state   <= MUL;
                                busyReg <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                aLat    <= mdu.a;
                                bLat    <= mdu.b;
                                opLat   <= mdu.op;
                                counter <= CNT_W'(DIV_CYCLES);
                                state   <= DIV;
                                busyReg <= 1'b1;
                            end
                            3'd4: hiReg <= mdu.a;
                            3'd5: loReg <= mdu.a;
`ifdef MDU_MADD_EN
                            3'd6: begin
                                aLat    <= mdu.a;
                                bLat    <= mdu.b;
                                opLat   <= mdu.op;
                                counter <= CNT_W'(MUL_CYCLES);
                                state   <= MUL;
                                busyReg <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                        case (opLat)
                            3'd0: {hiReg, loReg} <= prodS;
                            3'd1: {hiReg, loReg} <= prodU;
                            3'd2: if (!divZero) begin
                                hiReg <= remS;
                                loReg <= quotS;
                            end
                            3'd3: if (!divZero) begin
                                hiReg <= remU;
                                loReg <= quotU;
                            end
`ifdef MDU_MADD_EN
                            3'd6: {hiReg, loReg} <= {hiReg, loReg} + prodS;
`endif
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length are queued at issue
// and checked when busy drops. Build with MDU_MADD_EN to exercise the MADD path.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl_if bus();

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .mdu(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input int unsigned cyc);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        e.hi = eh;
        e.lo = el;
        e.cycles = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int unsigned n;
        exp_t e;
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        if (n !== e.cycles) begin
            bad++;
            $display("FAIL %s busy cycles: got %0d expected %0d", nm, n, e.cycles);
        end
        total++;
        if (bus.hi !== e.hi) begin
            bad++;
            $display("FAIL %s hi: got %h expected %h", nm, bus.hi, e.hi);
        end
        total++;
        if (bus.lo !== e.lo) begin
            bad++;
            $display("FAIL %s lo: got %h expected %h", nm, bus.lo, e.lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.d_is_md = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
        total++;
        if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset stall: got %b expected 0", bus.stall_req); end
        bus.d_is_md = 1'b0;
    endtask

    task automatic test_mult();
        logic [63:0] r;
        issue(3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_done("mult_neg");
        r = smul(32'h12345678, 32'h9ABCDEF0);
        issue(3'd0, 32'h12345678, 32'h9ABCDEF0, r[63:32], r[31:0], 5);
        wait_done("mult_model");
    endtask

    task automatic test_div();
        issue(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_done("div_neg");
        issue(3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 10);
        wait_done("divu");
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        wait_done("div_ovf");
    endtask

    task automatic test_divzero();
        issue(3'd4, 32'h11, 32'h0, 32'h11, 32'h80000000, 0);
        wait_done("mthi");
        issue(3'd5, 32'h22, 32'h0, 32'h11, 32'h22, 0);
        wait_done("mtlo");
        issue(3'd3, 32'h5, 32'h0, 32'h11, 32'h22, 10);
        wait_done("divu_zero");
        issue(3'd2, 32'h9, 32'h0, 32'h11, 32'h22, 10);
        wait_done("div_zero");
        bus.mf_sel = 1'b0;
        #1;
        total++;
        if (bus.mf_data !== 32'h11) begin bad++; $display("FAIL mf_hi: got %h expected 11", bus.mf_data); end
        bus.mf_sel = 1'b1;
        #1;
        total++;
        if (bus.mf_data !== 32'h22) begin bad++; $display("FAIL mf_lo: got %h expected 22", bus.mf_data); end
    endtask

    task automatic test_stall();
        int unsigned n;
        exp_t e;
        bus.d_is_md = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'hFFFFFFFF;
        e.hi = 32'hFFFFFFFE;
        e.lo = 32'h00000001;
        e.cycles = 5;
        sb.push_back(e);
        #1;
        total++;
        if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL stall_start: got %b expected 1", bus.stall_req); end
        @(negedge clk);
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            bus.start = (n == 2);
            bus.op    = 3'd5;
            bus.a     = 32'hDEAD;
            #1;
            total++;
            if (bus.stall_req !== 1'b1) begin
                bad++;
                $display("FAIL stall_busy%0d: got %b expected 1", n, bus.stall_req);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1;
        total++;
        if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL stall_after: got %b expected 0", bus.stall_req); end
        e = sb.pop_front();
        total++;
        if (n !== e.cycles) begin bad++; $display("FAIL stall busy cycles: got %0d expected %0d", n, e.cycles); end
        total++;
        if (bus.hi !== e.hi) begin bad++; $display("FAIL multu hi: got %h expected %h", bus.hi, e.hi); end
        total++;
        if (bus.lo !== e.lo) begin bad++; $display("FAIL multu lo: got %h expected %h", bus.lo, e.lo); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'h55;
        e.hi = 32'h55;
        e.lo = 32'h1;
        e.cycles = 0;
        sb.push_back(e);
        #1;
        total++;
        if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL mthi_stall: got %b expected 0", bus.stall_req); end
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("mthi_nostall");
        bus.d_is_md = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midreset pre busy: got %b expected 1", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL midreset hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        issue(3'd0, 32'd3, 32'd4, 32'h0, 32'd12, 5);
        wait_done("mult_after_reset");
    endtask

    task automatic test_madd();
        issue(3'd5, 32'd5, 32'h0, 32'h0, 32'd5, 0);
        wait_done("madd_setup");
`ifdef MDU_MADD_EN
        issue(3'd6, 32'd3, 32'd4, 32'h0, 32'd17, 5);
`else
        issue(3'd6, 32'd3, 32'd4, 32'h0, 32'd5, 0);
`endif
        wait_done("madd");
        issue(3'd7, 32'd9, 32'd9, 32'h0, bus.lo, 0);
        wait_done("op7_ignored");
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.a       = '0;
        bus.b       = '0;
        bus.d_is_md = 1'b0;
        bus.mf_sel  = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_stall();
        test_reset_mid();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
